dm_bus_ctrl: RTL and testbench
==============================

Name: dm_bus_ctrl

Overview:
- Data-memory access controller for the MEM stage. Sits directly upstream of the load-extension stage.
- Takes load/store requests from the MEM stage and checks alignment.
- Generates word-aligned bus address, byte enables and replicated store data.
- Runs a req/ack handshake with a wait-stated data bus and stalls the pipeline until the access completes.
- Delivers the raw 32-bit read word and the low address bits that the extension stage selects from.

Parameters:
- TIMEOUT, 16: max REQ cycles without bus_ack before the access is abandoned; legal range 1..255.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_re  in  1  load in MEM stage.
- mem_we  in  1  store in MEM stage.
- mem_size  in  2  0=word, 1=half, 2=byte, 3=word.
- addr  in  32  byte address from ALU.
- wdata  in  32  store data (rt), right-aligned.
- stall  out  1  freeze PC/IF/ID/EX/MEM registers.
- dmout  out  32  raw word read, for the extension stage.
- addr_lo  out  2  addr[1:0] of the completed load, for the extension stage.
- adel  out  1  load address error.
- ades  out  1  store address error.
- bus_timeout  out  1  one-cycle pulse when an access is abandoned.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  32  {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  replicated store data.
- bus_ack  in  1  bus completion, sampled in REQ.
- bus_rdata  in  32  valid when bus_ack=1.

Behaviour:
- Reset (async, immediate) clears everything:
  - FSM state to IDLE.
  - All outputs to 0.
  - Timeout counter to 0.
  - A reset mid-access drops bus_req immediately; no completion is reported.
- Request decode:
  - req = mem_re | mem_we.
  - If both are asserted, the access is treated as a store.
- Alignment check:
  - word: addr[1:0] must be 00.
  - half: addr[0] must be 0.
  - byte: always aligned.
- Byte enables:
  - word: 1111.
  - half: addr[1] ? 1100 : 0011.
  - byte: 0001 << addr[1:0].
- Store data:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- States: IDLE, REQ, DONE.
- IDLE:
  - Misaligned request: adel (load) or ades (store) is asserted combinationally, stall=0, and no bus transaction is issued.
  - Aligned request: stall=1 combinationally. At the clock edge, bus_addr/bus_be/bus_we/bus_wdata are registered, the counter is cleared, and the FSM goes to REQ.
- REQ:
  - bus_req=1, stall=1; bus outputs are held stable.
  - bus_ack=1: a load latches dmout<=bus_rdata and addr_lo<=captured addr[1:0]; go to DONE.
  - No ack and counter==TIMEOUT-1: pulse bus_timeout for one cycle, set dmout<=0 for a load, go to DONE.
  - Otherwise: increment the counter.
- DONE:
  - bus_req=0, stall=0; the pipeline advances at this edge.
  - Next state is IDLE unconditionally, so the same instruction is never reissued.
- Latency:
  - Minimum 2 stall cycles (IDLE, REQ with ack), then DONE.
  - Every extra wait cycle adds one stall cycle.
- dmout and addr_lo:
  - Both hold their values until the next load completes.
  - Stores never modify them.
- adel/ades are driven only in IDLE.

Test Plan:
- Aligned word load, addr=0x1004, ack in the first REQ cycle, rdata=0xDEADBEEF:
  - bus_be=1111, bus_addr=0x1004.
  - stall high for exactly 2 cycles.
  - dmout=0xDEADBEEF and addr_lo=00 in DONE.
- Byte store, addr=0x2003, wdata=0x000000A5, ack after 3 wait cycles:
  - bus_be=1000, bus_wdata=0xA5A5A5A5, bus_we=1.
  - stall high for 5 cycles.
  - dmout unchanged.
- Half load, addr=0x3002, rdata=0x12345678:
  - bus_be=1100, addr_lo=10, dmout=0x12345678.
- Misaligned accesses:
  - Word load at 0x1001: adel=1, stall=0, bus_req stays 0.
  - Half store at 0x1003: ades=1.
- No-ack timeout with TIMEOUT=4 on a load:
  - bus_req high for 4 cycles.
  - bus_timeout pulses once, dmout=0.
  - FSM passes through DONE, then returns to IDLE.
- Async reset asserted during REQ:
  - bus_req and stall drop to 0 before the next edge.
  - FSM is in IDLE; the following load completes normally.

Source files
------------

// File: rtl/dm_bus_ctrl.sv
// MEM-stage data-memory bus controller: alignment check, byte-lane formatting,
// req/ack handshake with timeout, and raw read-word delivery to the extension stage.
module dm_bus_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] dmout,
    output logic [1:0]  addr_lo,
    output logic        adel,
    output logic        ades,
    output logic        bus_timeout,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [1:0]  lo_q, lo_d;
    logic [31:0] dmout_q, dmout_d;
    logic [1:0]  addr_lo_q, addr_lo_d;
    logic        timeout_q, timeout_d;

    logic        req, is_store, aligned;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic        stall_c, adel_c, ades_c;

    assign req      = mem_re | mem_we;
    assign is_store = mem_we;

    // Size decode: 0 and 3 both mean word.
    always_comb begin
        aligned = (addr[1:0] == 2'b00);
        be_c    = 4'b1111;
        wdata_c = wdata;
        case (mem_size)
            2'd1: begin
                aligned = ~addr[0];
                be_c    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata[15:0]}};
            end
            2'd2: begin
                aligned = 1'b1;
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{wdata[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_we_d    = bus_we_q;
        bus_wdata_d = bus_wdata_q;
        lo_d        = lo_q;
        dmout_d     = dmout_q;
        addr_lo_d   = addr_lo_q;
        timeout_d   = 1'b0;
        stall_c     = 1'b0;
        adel_c      = 1'b0;
        ades_c      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (aligned) begin
                        stall_c     = 1'b1;
                        bus_addr_d  = {addr[31:2], 2'b00};
                        bus_be_d    = be_c;
                        bus_we_d    = is_store;
                        bus_wdata_d = wdata_c;
                        lo_d        = addr[1:0];
                        cnt_d       = 8'd0;
                        state_d     = S_REQ;
                    end else begin
                        adel_c = ~is_store;
                        ades_c = is_store;
                    end
                end
            end
            S_REQ: begin
                stall_c = 1'b1;
                if (bus_ack) begin
                    if (!bus_we_q) begin
                        dmout_d   = bus_rdata;
                        addr_lo_d = lo_q;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    // Abandoned load returns zero rather than stale data.
                    timeout_d = 1'b1;
                    if (!bus_we_q) begin
                        dmout_d = 32'd0;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            bus_addr_q  <= 32'd0;
            bus_be_q    <= 4'd0;
            bus_we_q    <= 1'b0;
            bus_wdata_q <= 32'd0;
            lo_q        <= 2'd0;
            dmout_q     <= 32'd0;
            addr_lo_q   <= 2'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_we_q    <= bus_we_d;
            bus_wdata_q <= bus_wdata_d;
            lo_q        <= lo_d;
            dmout_q     <= dmout_d;
            addr_lo_q   <= addr_lo_d;
            timeout_q   <= timeout_d;
        end
    end

    // Combinational outputs are forced low while reset is held.
    assign stall       = stall_c & ~reset;
    assign adel        = adel_c & ~reset;
    assign ades        = ades_c & ~reset;
    assign bus_req     = (state_q == S_REQ);
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;
    assign dmout       = dmout_q;
    assign addr_lo     = addr_lo_q;
    assign bus_timeout = timeout_q;

endmodule

// File: tb/tb_dm_bus_ctrl.sv
// Directed bench for dm_bus_ctrl: loads, stores, misalignment, timeout and mid-access reset.
module tb_dm_bus_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_re, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata;
    logic        stall;
    logic [31:0] dmout;
    logic [1:0]  addr_lo;
    logic        adel, ades, bus_timeout, bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int total = 0;
    int bad   = 0;

    // Results captured by run_access
    int          n_stall, n_req, n_tmo;
    bit          done_ok;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_we;

    always #5 clk = ~clk;

    dm_bus_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .mem_re(mem_re), .mem_we(mem_we), .mem_size(mem_size),
        .addr(addr), .wdata(wdata),
        .stall(stall), .dmout(dmout), .addr_lo(addr_lo),
        .adel(adel), .ades(ades), .bus_timeout(bus_timeout),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one access and hold it until DONE; ack after 'waits' REQ cycles (-1 = never).
    task automatic run_access(input logic re, input logic we, input logic [1:0] size,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int waits);
        @(posedge clk); #1;
        mem_re = re; mem_we = we; mem_size = size; addr = a; wdata = wd;
        bus_ack = 1'b0;
        n_stall = 0; n_req = 0; n_tmo = 0; done_ok = 1'b0;
        for (int i = 0; i < 40 && !done_ok; i++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            if (stall) n_stall++;
            if (bus_timeout) n_tmo++;
            if (bus_req) begin
                if (n_req == 0) begin
                    c_addr = bus_addr; c_be = bus_be; c_we = bus_we; c_wdata = bus_wdata;
                end
                if (n_req == waits) begin
                    bus_ack = 1'b1; bus_rdata = rd;
                end
                n_req++;
            end else if (n_req > 0 && !stall) begin
                done_ok = 1'b1;
            end
        end
        @(posedge clk); #1;
        mem_re = 1'b0; mem_we = 1'b0; bus_ack = 1'b0; bus_rdata = 32'hFFFF_FFFF;
    endtask

    initial begin
        reset = 1'b1; mem_re = 1'b0; mem_we = 1'b0; mem_size = 2'd0;
        addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_dmout", dmout, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        chk("rst_timeout", {31'd0, bus_timeout}, 32'd0);

        // Aligned word load, ack in first REQ cycle
        run_access(1'b1, 1'b0, 2'd0, 32'h0000_1004, 32'd0, 32'hDEAD_BEEF, 0);
        $display("word load 0x1004: stall=%0d req=%0d dmout=%h", n_stall, n_req, dmout);
        chk("ld_done", {31'd0, done_ok}, 32'd1);
        chk("ld_be", {28'd0, c_be}, 32'h0000_000F);
        chk("ld_addr", c_addr, 32'h0000_1004);
        chk("ld_we", {31'd0, c_we}, 32'd0);
        chk("ld_stall", n_stall, 2);
        chk("ld_dmout", dmout, 32'hDEAD_BEEF);
        chk("ld_addr_lo", {30'd0, addr_lo}, 32'd0);

        // Byte store, three wait cycles
        run_access(1'b0, 1'b1, 2'd2, 32'h0000_2003, 32'h0000_00A5, 32'h1111_1111, 3);
        $display("byte store 0x2003: stall=%0d be=%b wdata=%h", n_stall, c_be, c_wdata);
        chk("sb_be", {28'd0, c_be}, 32'h0000_0008);
        chk("sb_wdata", c_wdata, 32'hA5A5_A5A5);
        chk("sb_we", {31'd0, c_we}, 32'd1);
        chk("sb_addr", c_addr, 32'h0000_2000);
        chk("sb_stall", n_stall, 5);
        chk("sb_dmout", dmout, 32'hDEAD_BEEF);

        // Half load at upper half, one wait cycle
        run_access(1'b1, 1'b0, 2'd1, 32'h0000_3002, 32'd0, 32'h1234_5678, 1);
        $display("half load 0x3002: stall=%0d be=%b dmout=%h lo=%b", n_stall, c_be, dmout, addr_lo);
        chk("lh_be", {28'd0, c_be}, 32'h0000_000C);
        chk("lh_addr_lo", {30'd0, addr_lo}, 32'd2);
        chk("lh_dmout", dmout, 32'h1234_5678);
        chk("lh_stall", n_stall, 3);

        // Half store at lower half
        run_access(1'b0, 1'b1, 2'd1, 32'h0000_4000, 32'h0000_BEEF, 32'h2222_2222, 0);
        $display("half store 0x4000: be=%b wdata=%h", c_be, c_wdata);
        chk("sh_be", {28'd0, c_be}, 32'h0000_0003);
        chk("sh_wdata", c_wdata, 32'hBEEF_BEEF);

        // Both re and we: treated as a store
        run_access(1'b1, 1'b1, 2'd2, 32'h0000_5001, 32'h0000_003C, 32'h3333_3333, 0);
        $display("re+we byte 0x5001: be=%b we=%b dmout=%h", c_be, c_we, dmout);
        chk("rw_we", {31'd0, c_we}, 32'd1);
        chk("rw_be", {28'd0, c_be}, 32'h0000_0002);
        chk("rw_dmout", dmout, 32'h1234_5678);
        chk("rw_addr_lo", {30'd0, addr_lo}, 32'd2);

        // Misaligned word load
        @(posedge clk); #1;
        mem_re = 1'b1; mem_size = 2'd0; addr = 32'h0000_1001;
        #1;
        $display("misaligned lw 0x1001: adel=%b ades=%b stall=%b", adel, ades, stall);
        chk("mis_lw_adel", {31'd0, adel}, 32'd1);
        chk("mis_lw_ades", {31'd0, ades}, 32'd0);
        chk("mis_lw_stall", {31'd0, stall}, 32'd0);
        @(negedge clk); @(negedge clk);
        chk("mis_lw_req", {31'd0, bus_req}, 32'd0);
        chk("mis_lw_adel2", {31'd0, adel}, 32'd1);
        // Misaligned half store
        mem_re = 1'b0; mem_we = 1'b1; mem_size = 2'd1; addr = 32'h0000_1003;
        #1;
        $display("misaligned sh 0x1003: adel=%b ades=%b stall=%b", adel, ades, stall);
        chk("mis_sh_ades", {31'd0, ades}, 32'd1);
        chk("mis_sh_adel", {31'd0, adel}, 32'd0);
        // size=3 is a word: 0x1002 misaligned
        mem_we = 1'b0; mem_re = 1'b1; mem_size = 2'd3; addr = 32'h0000_1002;
        #1;
        $display("misaligned lw(size3) 0x1002: adel=%b", adel);
        chk("mis_s3_adel", {31'd0, adel}, 32'd1);
        @(negedge clk);
        chk("mis_s3_req", {31'd0, bus_req}, 32'd0);
        mem_re = 1'b0;

        // Timeout on a load (TIMEOUT=4)
        run_access(1'b1, 1'b0, 2'd0, 32'h0000_6008, 32'd0, 32'd0, -1);
        $display("timeout load 0x6008: req=%0d tmo=%0d stall=%0d dmout=%h", n_req, n_tmo, n_stall, dmout);
        chk("to_done", {31'd0, done_ok}, 32'd1);
        chk("to_req_cycles", n_req, 4);
        chk("to_pulses", n_tmo, 1);
        chk("to_stall", n_stall, 5);
        chk("to_dmout", dmout, 32'd0);
        @(negedge clk);
        chk("to_idle_tmo", {31'd0, bus_timeout}, 32'd0);
        chk("to_idle_req", {31'd0, bus_req}, 32'd0);

        // Async reset in REQ
        @(posedge clk); #1;
        mem_re = 1'b1; mem_size = 2'd0; addr = 32'h0000_7000; bus_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("ar_in_req", {31'd0, bus_req}, 32'd1);
        #1 reset = 1'b1;
        #1;
        $display("async reset in REQ: bus_req=%b stall=%b", bus_req, stall);
        chk("ar_req_drop", {31'd0, bus_req}, 32'd0);
        chk("ar_stall_drop", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0; mem_re = 1'b0;
        #1;
        chk("ar_idle_stall", {31'd0, stall}, 32'd0);
        chk("ar_dmout", dmout, 32'd0);
        run_access(1'b1, 1'b0, 2'd0, 32'h0000_7000, 32'd0, 32'hCAFE_F00D, 0);
        $display("load after reset 0x7000: stall=%0d dmout=%h", n_stall, dmout);
        chk("ar_ld_done", {31'd0, done_ok}, 32'd1);
        chk("ar_ld_stall", n_stall, 2);
        chk("ar_ld_dmout", dmout, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
